// File: rtl/i2c_target_rx_if.sv
// Pad-side and fabric-side signals of the write-only I2C target.
// master = bus/fabric environment, slave = the target itself.
interface i2c_target_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport master (
    output scl_in, sda_in,
    input  sda_out, rx_data, rx_valid, start_det, stop_det, busy
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_out, rx_data, rx_valid, start_det, stop_det, busy
  );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detect, 7-bit
// address match, ACK of matching writes, one-cycle strobe per data byte.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  i2c_target_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_q, sda_q;
  logic                   rise_q, fall_q, start_q, stop_q;

  state_e     state_q;
  logic [3:0] bit_ctr_q;
  logic [6:0] shift_q;
  logic [7:0] byte_d;
  logic       sda_out_q, rx_valid_q, start_det_q, stop_det_q, busy_q;
  logic [7:0] rx_data_q;

  assign scl_s  = scl_sync_q[SYNC_STAGES-1];
  assign sda_s  = sda_sync_q[SYNC_STAGES-1];
  assign byte_d = {shift_q, sda_q};

  // Synchronisers reset to the idle-bus level so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      rise_q     <= scl_s & ~scl_q;
      fall_q     <= ~scl_s & scl_q;
      start_q    <= scl_s & scl_q & sda_q & ~sda_s;
      stop_q     <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_ctr_q   <= 4'd0;
      shift_q     <= 7'd0;
      sda_out_q   <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      if (start_q) begin
        state_q     <= S_ADDR;
        bit_ctr_q   <= 4'd0;
        sda_out_q   <= 1'b1;
        busy_q      <= 1'b0;
        start_det_q <= 1'b1;
      end else if (stop_q) begin
        state_q     <= S_IDLE;
        bit_ctr_q   <= 4'd0;
        sda_out_q   <= 1'b1;
        busy_q      <= 1'b0;
        stop_det_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_ADDR: if (rise_q) begin
            shift_q   <= byte_d[6:0];
            bit_ctr_q <= bit_ctr_q + 4'd1;
            if (bit_ctr_q == 4'd7) begin
              bit_ctr_q <= 4'd0;
              // General call (7'h00) never equals TARGET_ADDR, so it lands here as a mismatch.
              if (byte_d[7:1] == TARGET_ADDR && !byte_d[0]) begin
                state_q <= S_ADDR_ACK;
                busy_q  <= 1'b1;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_DATA: if (rise_q) begin
            shift_q   <= byte_d[6:0];
            bit_ctr_q <= bit_ctr_q + 4'd1;
            if (bit_ctr_q == 4'd7) begin
              bit_ctr_q  <= 4'd0;
              rx_data_q  <= byte_d;
              rx_valid_q <= 1'b1;
              state_q    <= S_DATA_ACK;
            end
          end
          // First SCL fall pulls SDA low; the next fall (end of 9th clock) releases it.
          S_ADDR_ACK, S_DATA_ACK: if (fall_q) begin
            if (sda_out_q) begin
              sda_out_q <= 1'b0;
            end else begin
              sda_out_q <= 1'b1;
              state_q   <= S_DATA;
              bit_ctr_q <= 4'd0;
            end
          end
          S_IGNORE: sda_out_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_out   = sda_out_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C controller, a frame-level protocol
// model delayed by the synchroniser latency, and per-cycle comparison.
module tb_i2c_target_rx;
  localparam logic [6:0] ADDR = 7'h42;
  localparam int SYNC = 2;
  localparam int L    = SYNC + 1;
  localparam int H    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  i2c_target_rx_if bus ();
  assign bus.scl_in = scl_drv;
  assign bus.sda_in = sda_drv & bus.sda_out;

  i2c_target_rx #(.TARGET_ADDR(ADDR), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Protocol model: consumes pad samples L clocks late, tracks frames
  logic       hs [0:L+1];
  logic       hd [0:L+1];
  logic       m_act = 0, m_ign = 0, m_addressed = 0, m_ack_this = 0, m_low = 0;
  logic       m_start = 0, m_stop = 0, m_valid = 0;
  logic [7:0] m_acc = 0, m_data = 0;
  int         m_rises = 0, m_frame = 0;

  initial begin
    for (int i = 0; i <= L + 1; i++) begin hs[i] = 1'b1; hd[i] = 1'b1; end
    forever begin
      @(posedge clk or posedge reset);
      m_start = 0; m_stop = 0; m_valid = 0;
      if (reset) begin
        for (int i = 0; i <= L + 1; i++) begin hs[i] = 1'b1; hd[i] = 1'b1; end
        m_act = 0; m_ign = 0; m_addressed = 0; m_ack_this = 0; m_low = 0;
        m_acc = 0; m_data = 0; m_rises = 0; m_frame = 0;
      end else begin
        for (int i = L + 1; i > 0; i--) begin hs[i] = hs[i-1]; hd[i] = hd[i-1]; end
        hs[0] = bus.scl_in;
        hd[0] = bus.sda_in;
        if (hs[L] && hs[L+1] && hd[L+1] && !hd[L]) begin
          m_start = 1; m_act = 1; m_ign = 0; m_addressed = 0; m_ack_this = 0;
          m_low = 0; m_frame = 0; m_rises = 0; m_acc = 0;
        end else if (hs[L] && hs[L+1] && !hd[L+1] && hd[L]) begin
          m_stop = 1; m_act = 0; m_ign = 0; m_addressed = 0; m_low = 0; m_rises = 0;
        end else if (m_act && !m_ign) begin
          if (hs[L] && !hs[L+1]) begin
            m_rises++;
            if (m_rises <= 8) m_acc = {m_acc[6:0], hd[L]};
            if (m_rises == 8) begin
              if (m_frame == 0) begin
                m_ack_this  = (m_acc[7:1] == ADDR) && !m_acc[0];
                m_addressed = m_ack_this;
                m_ign       = !m_ack_this;
              end else begin
                m_valid = 1; m_data = m_acc; m_ack_this = 1;
              end
            end
          end else if (!hs[L] && hs[L+1]) begin
            if (m_rises == 8 && m_ack_this) m_low = 1;
            else if (m_rises == 9) begin m_low = 0; m_rises = 0; m_frame++; end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model plus event monitors
  int         c_start = 0, c_stop = 0, c_valid = 0, cyc_fail_prints = 0;
  logic       busy_seen = 0, low_seen = 0;
  logic [7:0] dlog [0:7];

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        n_checks++;
        if ({bus.sda_out, bus.rx_data, bus.rx_valid, bus.start_det, bus.stop_det, bus.busy} !==
            {!m_low, m_data, m_valid, m_start, m_stop, m_addressed}) begin
          n_fail++;
          if (cyc_fail_prints < 20) begin
            cyc_fail_prints++;
            $display("FAIL cycle t=%0t got sda=%b d=%h v=%b st=%b sp=%b b=%b exp sda=%b d=%h v=%b st=%b sp=%b b=%b",
                     $time, bus.sda_out, bus.rx_data, bus.rx_valid, bus.start_det, bus.stop_det, bus.busy,
                     !m_low, m_data, m_valid, m_start, m_stop, m_addressed);
          end
        end
        if (bus.start_det) c_start++;
        if (bus.stop_det) c_stop++;
        if (bus.rx_valid) begin
          if (c_valid < 8) dlog[c_valid] = bus.rx_data;
          c_valid++;
        end
        if (bus.busy) busy_seen = 1;
        if (!bus.sda_out) low_seen = 1;
      end
    end
  end

  task automatic clr();
    c_start = 0; c_stop = 0; c_valid = 0; busy_seen = 0; low_seen = 0;
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1; w(H); scl_drv = 1; w(H); sda_drv = 0; w(H); scl_drv = 0; w(H);
  endtask

  task automatic bus_stop();
    sda_drv = 0; w(H); scl_drv = 1; w(H); sda_drv = 1; w(2*H);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b; w(H); scl_drv = 1; w(H); scl_drv = 0;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    sda_drv = 1; w(H); scl_drv = 1; w(H/2);
    ack = bus.sda_in;
    w(H/2); scl_drv = 0;
  endtask

  logic       ack;
  logic [7:0] b84;
  int         k;

  initial begin
    // Reset
    w(3);
    chk("rst_sda_out", bus.sda_out, 1);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_start_det", bus.start_det, 0);
    chk("rst_stop_det", bus.stop_det, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 0;
    w(10);
    chk("post_rst_sda_out", bus.sda_out, 1);
    chk("post_rst_busy", bus.busy, 0);

    // Matched write
    clr();
    bus_start();
    write_byte(8'h84, ack); chk("mw_addr_ack", ack, 0);
    write_byte(8'hA5, ack); chk("mw_d0_ack", ack, 0);
    write_byte(8'h3C, ack); chk("mw_d1_ack", ack, 0);
    chk("mw_busy_mid", bus.busy, 1);
    bus_stop();
    chk("mw_starts", c_start, 1);
    chk("mw_stops", c_stop, 1);
    chk("mw_valids", c_valid, 2);
    chk("mw_data0", dlog[0], 8'hA5);
    chk("mw_data1", dlog[1], 8'h3C);
    chk("mw_busy_end", bus.busy, 0);
    chk("mw_model_data", m_data, 8'h3C);

    // Address mismatch
    clr();
    bus_start();
    write_byte(8'h86, ack); chk("mm_addr_nack", ack, 1);
    write_byte(8'hFF, ack); chk("mm_data_nack", ack, 1);
    bus_stop();
    chk("mm_valids", c_valid, 0);
    chk("mm_busy_seen", busy_seen, 0);
    chk("mm_low_seen", low_seen, 0);

    // Read request
    clr();
    bus_start();
    write_byte(8'h85, ack); chk("rd_nack", ack, 1);
    chk("rd_model_busy", m_addressed, 0);
    bus_stop();
    chk("rd_valids", c_valid, 0);
    chk("rd_low_seen", low_seen, 0);

    // Repeated START in the middle of a data byte
    clr();
    bus_start();
    write_byte(8'h84, ack); chk("rs_addr_ack0", ack, 0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    bus_start();
    chk("rs_busy_after_rstart", bus.busy, 0);
    write_byte(8'h84, ack); chk("rs_addr_ack1", ack, 0);
    write_byte(8'h11, ack); chk("rs_data_ack", ack, 0);
    bus_stop();
    chk("rs_starts", c_start, 2);
    chk("rs_valids", c_valid, 1);
    chk("rs_data", dlog[0], 8'h11);

    // Reset while the target is pulling SDA low
    clr();
    b84 = 8'h84;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(b84[i]);
    k = 0;
    while (bus.sda_out !== 1'b0 && k < 30) begin w(1); k++; end
    chk("ra_ack_seen", (k < 30), 1);
    #2 reset = 1;
    #1 chk("ra_async_release", bus.sda_out, 1);
    chk("ra_busy_cleared", bus.busy, 0);
    w(3);
    reset = 0;
    clr();
    write_bit(1'b1);
    write_byte(8'h55, ack); chk("ra_ignored_nack", ack, 1);
    bus_stop();
    chk("ra_valids", c_valid, 0);
    chk("ra_busy_seen", busy_seen, 0);
    clr();
    bus_start();
    write_byte(8'h84, ack); chk("ra_new_addr_ack", ack, 0);
    write_byte(8'h3C, ack); chk("ra_new_data_ack", ack, 0);
    bus_stop();
    chk("ra_new_valids", c_valid, 1);
    chk("ra_new_data", dlog[0], 8'h3C);

    w(4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Write-only I2C target (slave) that is the far end of our I2C controller's start/hold/address/data sequencing. Oversamples SCL/SDA on the system clock, detects START/repeated-START/STOP, matches a 7-bit address, ACKs matching write transfers and delivers each received data byte as a one-cycle strobe to fabric logic. Sits behind the pad open-drain buffers, alongside the controller in the same I2C subsystem.

## Interface
- `TARGET_ADDR`, 7'h42, 7-bit address this target answers to.
- `SYNC_STAGES`, 2, synchroniser depth on `scl_in`/`sda_in` (legal 2..4).
- `clk`  input  1  system clock; must be ≥ 8× SCL frequency.
- `reset`  input  1  one clock; reset is asynchronous and active-high.
- `scl_in`  input  1  SCL pad level, asynchronous.
- `sda_in`  input  1  SDA pad level, asynchronous.
- `sda_out`  output  1  open-drain control: 0 = pull SDA low, 1 = release.
- `rx_data`  output  8  last received data byte, MSB first on the wire.
- `rx_valid`  output  1  one-cycle strobe, `rx_data` newly updated.
- `start_det`  output  1  one-cycle strobe on START or repeated START.
- `stop_det`  output  1  one-cycle strobe on STOP.
- `busy`  output  1  high from START to STOP while addressed (address matched, write).

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one more flop for edge detection (`scl_q`, `sda_q`). All decisions use synchronised values only.
- START: synced SDA 1→0 while synced SCL = 1. STOP: synced SDA 0→1 while synced SCL = 1. Both take priority over bit sampling in the same cycle.
- Bits sampled on synced SCL rising edge; 4-bit counter `bit_ctr` counts 0..7 then ACK slot.
- States:
  - `s_idle`: sda_out = 1. START → `s_addr`, bit_ctr = 0.
  - `s_addr`: shift 8 bits (7 address + R/W). After 8th bit: address match and R/W = 0 → `s_addr_ack`; otherwise → `s_ignore`.
  - `s_addr_ack`: on next SCL falling edge drive sda_out = 0; hold through SCL high; release on following SCL falling edge → `s_data`, bit_ctr = 0; `busy` = 1 from entering this state.
  - `s_data`: shift 8 bits; after 8th bit load `rx_data`, pulse `rx_valid` → `s_data_ack`.
  - `s_data_ack`: same ACK drive/release as `s_addr_ack` → `s_data`.
  - `s_ignore`: sda_out = 1 always; waits for START or STOP.
- STOP in any state → `s_idle`, sda_out = 1, busy = 0, partial byte discarded, no `rx_valid`.
- START (repeated) in any state → `s_addr`, bit_ctr = 0, sda_out = 1, partial byte discarded; busy cleared until the new address matches.
- Read requests (R/W = 1) are NACKed (SDA released) and ignored; general-call (7'h00) not supported, treated as mismatch.
- Target never stretches SCL.

## Timing
- Reset values: sda_out = 1, rx_data = 8'h00, rx_valid = 0, start_det = 0, stop_det = 0, busy = 0, state `s_idle`, bit_ctr = 0. Asserting reset mid-ACK releases SDA immediately (asynchronous).
- Pin-to-detection latency: `SYNC_STAGES` + 1 clocks from pad edge to internal edge flag; strobes assert the cycle after that.
- `rx_valid` asserts exactly once per byte, in the cycle after the 8th data bit's SCL rising edge is detected; `rx_data` holds until the next byte's strobe.
- ACK low begins `SYNC_STAGES` + 2 clocks after the 8th SCL falling pad edge; released `SYNC_STAGES` + 2 clocks after the 9th SCL falling pad edge — inside SCL-low, never while SCL high.
- `start_det`/`stop_det`/`rx_valid` are single-cycle; never two of them in the same cycle except none.

## Test plan
- Reset: assert reset with SDA/SCL high → all outputs at reset values; deassert → stays `s_idle`, sda_out = 1.
- Matched write: START, 0x84 (7'h42 + W), data 0xA5, 0x3C, STOP → start_det once, ACK low on 9th clock of each of 3 bytes, rx_valid twice with rx_data 0xA5 then 0x3C, stop_det once, busy 1→0.
- Address mismatch: START, 0x86, data 0xFF, STOP → sda_out stays 1 throughout, no rx_valid, busy stays 0.
- Read request: START, 0x85 → NACK (sda_out = 1 at 9th clock), no rx_valid until STOP.
- Repeated START mid-byte: START, 0x84, ACK, 4 bits of 0xF0, START, 0x84, 0x11, STOP → no strobe for partial byte, start_det twice, single rx_valid with 0x11.
- Reset during ACK: assert reset while sda_out = 0 → sda_out = 1 same cycle, state `s_idle`, following bus traffic ignored until next START.
